// File: rtl/fm_stereo_sample_sequencer.sv
// Stereo sample FIFO plus zero-order-hold sequencer feeding the 192 kHz FM stereo modulator.
// Kp/Kf updates are deferred to sample boundaries, and hold-period underruns are counted.
module fm_stereo_sample_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned HOLD   = 4,
  parameter logic [3:0]  KP_RST = 4'b1000,
  parameter logic [7:0]  KF_RST = 8'b00110000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clken_48,
  input  logic        clken_192,
  input  logic        in_valid,
  input  logic [17:0] in_left,
  input  logic [17:0] in_right,
  output logic        in_ready,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_kp,
  input  logic [7:0]  cfg_kf,
  input  logic        ready_block_192,
  output logic [17:0] LI_LEFT,
  output logic [17:0] LI_RIGHT,
  output logic [3:0]  Kp,
  output logic [7:0]  Kf,
  output logic [2:0]  fifo_level,
  output logic [7:0]  underrun_count,
  output logic        running
);

  localparam int unsigned DATA_W = 18;
  localparam int unsigned LVL_W  = 3;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } pair_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    UNDERRUN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_d;
  logic                in_ready_d;
  logic [DATA_W-1:0]   li_left_d, li_right_d;
  logic [3:0]          kp_d, pend_kp_q, pend_kp_d;
  logic [7:0]          kf_d, pend_kf_q, pend_kf_d;
  logic                pend_q, pend_d;
  logic [7:0]          ucnt_d;
  logic                running_d;
  logic                ce, push, load, apply, fifo_empty;
  pair_t               mem [0:DEPTH-1];
  pair_t               head;

  // clken_48 is a status-only strobe; the hold/underrun logic runs purely on consume events.
  logic unused_clken_48;
  assign unused_clken_48 = clken_48;

  assign ce         = ready_block_192 && clken_192;
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr_q];

  // Sample storage; contents need no reset because the pointers and level define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= pair_t'({in_left, in_right});
    end
  end

  // Next-state, hold counter, FIFO bookkeeping and configuration staging.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    li_left_d  = LI_LEFT;
    li_right_d = LI_RIGHT;
    ucnt_d     = underrun_count;
    load       = 1'b0;
    apply      = 1'b0;
    kp_d       = Kp;
    kf_d       = Kf;
    pend_d     = pend_q;
    pend_kp_d  = pend_kp_q;
    pend_kf_d  = pend_kf_q;

    case (state_q)
      IDLE, UNDERRUN: begin
        li_left_d  = '0;
        li_right_d = '0;
        apply      = pend_q;
        if (ce && !fifo_empty) begin
          load    = 1'b1;
          hold_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (ce) begin
          if (hold_q != HOLD_W'(HOLD - 1)) begin
            hold_d = hold_q + HOLD_W'(1);
          end else if (!fifo_empty) begin
            load   = 1'b1;
            hold_d = '0;
            apply  = pend_q;
          end else begin
            li_left_d  = '0;
            li_right_d = '0;
            hold_d     = '0;
            state_d    = UNDERRUN;
            if (underrun_count != 8'hFF) begin
              ucnt_d = underrun_count + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      li_left_d  = head.left;
      li_right_d = head.right;
    end

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(load);
    level_d    = fifo_level + LVL_W'(push) - LVL_W'(load);
    in_ready_d = (level_d != LVL_W'(DEPTH));
    running_d  = (state_d == RUN);

    // A write landing on an application edge stays pending for the next boundary.
    if (apply) begin
      kp_d   = pend_kp_q;
      kf_d   = pend_kf_q;
      pend_d = 1'b0;
    end
    if (cfg_we) begin
      pend_kp_d = cfg_kp;
      pend_kf_d = cfg_kf;
      pend_d    = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_level     <= '0;
      in_ready       <= 1'b1;
      LI_LEFT        <= '0;
      LI_RIGHT       <= '0;
      Kp             <= KP_RST;
      Kf             <= KF_RST;
      pend_q         <= 1'b0;
      pend_kp_q      <= '0;
      pend_kf_q      <= '0;
      underrun_count <= '0;
      running        <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_level     <= level_d;
      in_ready       <= in_ready_d;
      LI_LEFT        <= li_left_d;
      LI_RIGHT       <= li_right_d;
      Kp             <= kp_d;
      Kf             <= kf_d;
      pend_q         <= pend_d;
      pend_kp_q      <= pend_kp_d;
      pend_kf_q      <= pend_kf_d;
      underrun_count <= ucnt_d;
      running        <= running_d;
    end
  end

endmodule

// File: tb/tb_fm_stereo_sample_sequencer.sv
// Self-checking bench for fm_stereo_sample_sequencer: vector table, directed corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_fm_stereo_sample_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 4;

  logic        clock;
  logic        reset;
  logic        clken_48;
  logic        clken_192;
  logic        in_valid;
  logic [17:0] in_left;
  logic [17:0] in_right;
  logic        in_ready;
  logic        cfg_we;
  logic [3:0]  cfg_kp;
  logic [7:0]  cfg_kf;
  logic        ready_block_192;
  logic [17:0] LI_LEFT;
  logic [17:0] LI_RIGHT;
  logic [3:0]  Kp;
  logic [7:0]  Kf;
  logic [2:0]  fifo_level;
  logic [7:0]  underrun_count;
  logic        running;

  fm_stereo_sample_sequencer #(
    .DEPTH (DEPTH),
    .HOLD  (HOLD),
    .KP_RST(4'b1000),
    .KF_RST(8'b00110000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .clken_48       (clken_48),
    .clken_192      (clken_192),
    .in_valid       (in_valid),
    .in_left        (in_left),
    .in_right       (in_right),
    .in_ready       (in_ready),
    .cfg_we         (cfg_we),
    .cfg_kp         (cfg_kp),
    .cfg_kf         (cfg_kf),
    .ready_block_192(ready_block_192),
    .LI_LEFT        (LI_LEFT),
    .LI_RIGHT       (LI_RIGHT),
    .Kp             (Kp),
    .Kf             (Kf),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count),
    .running        (running)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pairs and a count of consume events left for the current sample.
  typedef struct packed {
    logic [17:0] l;
    logic [17:0] r;
  } pair_t;

  pair_t       m_q[$];
  bit          m_playing;
  int          m_left;
  logic [17:0] m_li_l, m_li_r;
  int          m_ucnt;
  logic [3:0]  m_kp, m_pkp;
  logic [7:0]  m_kf, m_pkf;
  bit          m_pend;
  bit          m_ready;

  task automatic model_reset();
    m_q.delete();
    m_playing = 1'b0;
    m_left    = 0;
    m_li_l    = '0;
    m_li_r    = '0;
    m_ucnt    = 0;
    m_kp      = 4'h8;
    m_kf      = 8'h30;
    m_pkp     = '0;
    m_pkf     = '0;
    m_pend    = 1'b0;
    m_ready   = 1'b1;
  endtask

  task automatic model_step();
    bit    ce, push, had, load, apply;
    pair_t h;
    ce    = clken_192 && ready_block_192;
    push  = in_valid && m_ready;
    had   = (m_q.size() > 0);
    load  = 1'b0;
    apply = m_pend && !m_playing;
    if (ce) begin
      if (!m_playing) begin
        if (had) load = 1'b1;
      end else if (m_left > 1) begin
        m_left--;
      end else if (had) begin
        load  = 1'b1;
        apply = m_pend;
      end else begin
        m_playing = 1'b0;
        m_li_l    = '0;
        m_li_r    = '0;
        if (m_ucnt < 255) m_ucnt++;
      end
    end
    if (load) begin
      h         = m_q.pop_front();
      m_li_l    = h.l;
      m_li_r    = h.r;
      m_left    = HOLD;
      m_playing = 1'b1;
    end
    if (push) begin
      h.l = in_left;
      h.r = in_right;
      m_q.push_back(h);
    end
    if (apply) begin
      m_kp   = m_pkp;
      m_kf   = m_pkf;
      m_pend = 1'b0;
    end
    if (cfg_we) begin
      m_pkp  = cfg_kp;
      m_pkf  = cfg_kf;
      m_pend = 1'b1;
    end
    m_ready = (m_q.size() != DEPTH);
  endtask

  task automatic check_model();
    chk("model LI_LEFT", 32'(LI_LEFT), 32'(m_li_l));
    chk("model LI_RIGHT", 32'(LI_RIGHT), 32'(m_li_r));
    chk("model fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("model in_ready", 32'(in_ready), 32'(m_ready));
    chk("model running", 32'(running), 32'(m_playing));
    chk("model underrun_count", 32'(underrun_count), 32'(m_ucnt));
    chk("model Kp", 32'(Kp), 32'(m_kp));
    chk("model Kf", 32'(Kf), 32'(m_kf));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    check_model();
  endtask

  task automatic set_in(input logic v, input logic [17:0] l, input logic [17:0] r,
                        input logic c192, input logic rdy);
    in_valid        = v;
    in_left         = l;
    in_right        = r;
    clken_192       = c192;
    ready_block_192 = rdy;
    cfg_we          = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " LI_LEFT"}, 32'(LI_LEFT), 32'd0);
    chk({tag, " LI_RIGHT"}, 32'(LI_RIGHT), 32'd0);
    chk({tag, " Kp"}, 32'(Kp), 32'h8);
    chk({tag, " Kf"}, 32'(Kf), 32'h30);
    chk({tag, " fifo_level"}, 32'(fifo_level), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " running"}, 32'(running), 32'd0);
    chk({tag, " underrun_count"}, 32'(underrun_count), 32'd0);
  endtask

  typedef struct {
    logic        v;
    logic [17:0] l;
    logic [17:0] r;
    logic        c192;
    logic        rdy;
    logic [17:0] e_l;
    logic [17:0] e_r;
    logic [2:0]  e_lvl;
    logic        e_rdy;
    logic        e_run;
    logic [7:0]  e_ucnt;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Single pair through load, hold and underrun, then FIFO fill with a blocked 5th pair.
    tbl[0]  = '{1'b1, 18'd12,  18'd271,     1'b0, 1'b0, 18'd0,   18'd0,       3'd1, 1'b1, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 18'd0,   18'd0,       1'b1, 1'b1, 18'd12,  18'd271,     3'd0, 1'b1, 1'b1, 8'd0};
    tbl[2]  = '{1'b0, 18'd0,   18'd0,       1'b0, 1'b1, 18'd12,  18'd271,     3'd0, 1'b1, 1'b1, 8'd0};
    tbl[3]  = '{1'b0, 18'd0,   18'd0,       1'b1, 1'b1, 18'd12,  18'd271,     3'd0, 1'b1, 1'b1, 8'd0};
    tbl[4]  = '{1'b0, 18'd0,   18'd0,       1'b1, 1'b1, 18'd12,  18'd271,     3'd0, 1'b1, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 18'd0,   18'd0,       1'b1, 1'b1, 18'd12,  18'd271,     3'd0, 1'b1, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 18'd0,   18'd0,       1'b1, 1'b1, 18'd0,   18'd0,       3'd0, 1'b1, 1'b0, 8'd1};
    tbl[7]  = '{1'b0, 18'd0,   18'd0,       1'b1, 1'b1, 18'd0,   18'd0,       3'd0, 1'b1, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 18'd101, 18'h3FF01,   1'b0, 1'b0, 18'd0,   18'd0,       3'd1, 1'b1, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 18'd102, 18'h3FF02,   1'b0, 1'b0, 18'd0,   18'd0,       3'd2, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 18'd103, 18'h3FF03,   1'b0, 1'b0, 18'd0,   18'd0,       3'd3, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 18'd104, 18'h3FF04,   1'b0, 1'b0, 18'd0,   18'd0,       3'd4, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b1, 18'd105, 18'h3FF05,   1'b0, 1'b0, 18'd0,   18'd0,       3'd4, 1'b0, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 18'd105, 18'h3FF05,   1'b1, 1'b1, 18'd101, 18'h3FF01,   3'd3, 1'b1, 1'b1, 8'd1};
    tbl[14] = '{1'b1, 18'd105, 18'h3FF05,   1'b0, 1'b0, 18'd101, 18'h3FF01,   3'd4, 1'b0, 1'b1, 8'd1};

    reset     = 1'b0;
    clken_48  = 1'b0;
    cfg_kp    = '0;
    cfg_kf    = '0;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    chk_reset_values("reset");
    model_reset();
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].c192, tbl[i].rdy);
      cycle();
      chk($sformatf("vec%0d LI_LEFT", i), 32'(LI_LEFT), 32'(tbl[i].e_l));
      chk($sformatf("vec%0d LI_RIGHT", i), 32'(LI_RIGHT), 32'(tbl[i].e_r));
      chk($sformatf("vec%0d fifo_level", i), 32'(fifo_level), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d running", i), 32'(running), 32'(tbl[i].e_run));
      chk($sformatf("vec%0d underrun_count", i), 32'(underrun_count), 32'(tbl[i].e_ucnt));
    end

    // Config written twice mid-hold: last write wins, applied only at the next load.
    set_in(1'b0, '0, '0, 1'b1, 1'b1);
    cycle();
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_kp = 4'd2; cfg_kf = 8'h10;
    cycle();
    chk("cfg1 Kp", 32'(Kp), 32'h8);
    chk("cfg1 Kf", 32'(Kf), 32'h30);
    cfg_we = 1'b1; cfg_kp = 4'd3; cfg_kf = 8'h20;
    cycle();
    chk("cfg2 Kp", 32'(Kp), 32'h8);
    chk("cfg2 Kf", 32'(Kf), 32'h30);
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, '0, '0, 1'b1, 1'b1);
      cycle();
      chk("cfg hold Kp", 32'(Kp), 32'h8);
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b1);
    cycle();
    chk("cfg load Kp", 32'(Kp), 32'h3);
    chk("cfg load Kf", 32'(Kf), 32'h20);
    chk("cfg load LI_LEFT", 32'(LI_LEFT), 32'd102);
    chk("cfg load fifo_level", 32'(fifo_level), 32'd3);

    // clken_192 pulsing with the modulator not ready must freeze everything.
    for (int k = 0; k < 40; k++) begin
      set_in(1'b0, '0, '0, (k % 4) == 0, 1'b0);
      cycle();
      chk("freeze LI_LEFT", 32'(LI_LEFT), 32'd102);
      chk("freeze running", 32'(running), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      set_in(1'b0, '0, '0, 1'b1, 1'b1);
      cycle();
      chk("post-freeze hold LI_LEFT", 32'(LI_LEFT), 32'd102);
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b1);
    cycle();
    chk("post-freeze load LI_RIGHT", 32'(LI_RIGHT), 32'h3FF03);
    chk("post-freeze fifo_level", 32'(fifo_level), 32'd2);

    // Asynchronous reset between edges while running with two pairs queued.
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_values("async reset");
    model_reset();
    #2;
    reset = 1'b1;

    // In IDLE a captured config applies on the following edge.
    cfg_we = 1'b1; cfg_kp = 4'd5; cfg_kf = 8'h55;
    cycle();
    chk("idle cfg capture Kp", 32'(Kp), 32'h8);
    cfg_we = 1'b0;
    cycle();
    chk("idle cfg apply Kp", 32'(Kp), 32'h5);
    chk("idle cfg apply Kf", 32'(Kf), 32'h55);

    // 48 kHz stream of three pairs with the modulator always ready.
    for (int t = 0; t < 56; t++) begin
      clken_48 = (t % 16) == 0;
      set_in((t % 16) == 0 && t < 48, 18'(12 + t / 16), 18'(271 - t / 16), (t % 4) == 1, 1'b1);
      cycle();
      if (t >= 1 && t <= 48) begin
        chk("stream running", 32'(running), 32'd1);
        chk("stream no underrun", 32'(underrun_count), 32'd0);
      end
    end
    clken_48 = 1'b0;
    chk("stream end underrun_count", 32'(underrun_count), 32'd1);

    // Repeated single-pair underruns drive the counter into saturation.
    for (int n = 0; n < 260; n++) begin
      set_in(1'b1, 18'($urandom), 18'($urandom), 1'b0, 1'b0);
      cycle();
      for (int k = 0; k < 5; k++) begin
        set_in(1'b0, '0, '0, 1'b1, 1'b1);
        cycle();
      end
    end
    chk("saturated underrun_count", 32'(underrun_count), 32'd255);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 2) == 0, 18'($urandom), 18'($urandom),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
      clken_48 = $urandom_range(0, 3) == 0;
      cfg_we   = $urandom_range(0, 19) == 0;
      cfg_kp   = 4'($urandom);
      cfg_kf   = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
